// File: rtl/hit_judge_pkg.sv
// Shared widths, FSM state encoding and the X-distance helper for the hit judge.
package hit_judge_pkg;

    localparam int COORD_W = 5;
    localparam int SCORE_W = 8;
    localparam int LIVES_W = 2;
    localparam int TIMER_W = 10;

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_JUDGE  = 3'd1,
        ST_REPORT = 3'd2,
        ST_HOLD   = 3'd3,
        ST_OVER   = 3'd4
    } state_e;

    // Absolute X distance computed from a 6-bit two's-complement difference.
    function automatic logic [COORD_W:0] abs_dx(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b);
        logic [COORD_W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return diff[COORD_W] ? (~diff + 1'b1) : diff;
    endfunction

endpackage

// File: rtl/hit_judge_round_timer.sv
// Round timer: counts WAIT cycles and flags when the shot window has expired.
module round_timer
    import hit_judge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/hit_judge.sv
// Shooting-game round judge: accepts a shot, compares it with the target,
// reports the outcome and keeps score and lives.
module hit_judge
    import hit_judge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 200,
    parameter int unsigned LIVES          = 3,
    parameter int unsigned TOL            = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] target_x,
    input  logic [COORD_W-1:0] target_y,
    input  logic               shot_valid,
    input  logic [COORD_W-1:0] shot_x,
    input  logic [COORD_W-1:0] shot_y,
    output logic               shot_ready,
    input  logic               restart,
    output logic               result_valid,
    output logic               result_hit,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives,
    output logic               game_over
);

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [COORD_W:0]   TOL_V      = (COORD_W + 1)'(TOL);

    state_e             state_q;
    state_e             state_d;
    logic [COORD_W-1:0] shot_x_q;
    logic [COORD_W-1:0] shot_x_d;
    logic [COORD_W-1:0] shot_y_q;
    logic [COORD_W-1:0] shot_y_d;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] score_d;
    logic [LIVES_W-1:0] lives_q;
    logic [LIVES_W-1:0] lives_d;
    logic               result_hit_q;
    logic               result_hit_d;

    logic timer_expired;
    logic accept;
    logic timeout;
    logic judge_hit;
    logic round_done;
    logic round_hit;
    logic restart_ok;

    round_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_round_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (state_q != ST_WAIT),
        .en_i     (state_q == ST_WAIT),
        .expired_o(timer_expired)
    );

    // A shot presented in the expiry cycle takes priority over the timeout.
    assign accept     = (state_q == ST_WAIT) && shot_valid;
    assign timeout    = (state_q == ST_WAIT) && !shot_valid && timer_expired;
    assign judge_hit  = (abs_dx(shot_x_q, target_x) <= TOL_V) && (shot_y_q == target_y);
    assign round_done = (state_q == ST_JUDGE) || timeout;
    assign round_hit  = (state_q == ST_JUDGE) && judge_hit;
    assign restart_ok = (state_q == ST_OVER) && restart;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT: begin
                if (shot_valid) begin
                    state_d = ST_JUDGE;
                end else if (timer_expired) begin
                    state_d = ST_REPORT;
                end
            end
            ST_JUDGE:  state_d = ST_REPORT;
            ST_REPORT: state_d = (lives_q != '0) ? ST_HOLD : ST_OVER;
            ST_HOLD:   state_d = ST_WAIT;
            ST_OVER: begin
                if (restart) begin
                    state_d = ST_WAIT;
                end
            end
            default:   state_d = ST_WAIT;
        endcase
    end

    always_comb begin
        shot_ready   = (state_q == ST_WAIT);
        result_valid = (state_q == ST_REPORT);
        game_over    = (state_q == ST_OVER);
    end

    // Score, lives and outcome all update on the edge that enters REPORT.
    always_comb begin
        shot_x_d     = shot_x_q;
        shot_y_d     = shot_y_q;
        score_d      = score_q;
        lives_d      = lives_q;
        result_hit_d = result_hit_q;
        if (accept) begin
            shot_x_d = shot_x;
            shot_y_d = shot_y;
        end
        if (round_done) begin
            result_hit_d = round_hit;
            if (round_hit) begin
                if (score_q != '1) begin
                    score_d = score_q + 1'b1;
                end
            end else if (lives_q != '0) begin
                lives_d = lives_q - 1'b1;
            end
        end
        if (restart_ok) begin
            score_d      = '0;
            lives_d      = LIVES_INIT;
            result_hit_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shot_x_q     <= '0;
            shot_y_q     <= '0;
            score_q      <= '0;
            lives_q      <= LIVES_INIT;
            result_hit_q <= 1'b0;
        end else begin
            shot_x_q     <= shot_x_d;
            shot_y_q     <= shot_y_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            result_hit_q <= result_hit_d;
        end
    end

    assign score      = score_q;
    assign lives      = lives_q;
    assign result_hit = result_hit_q;

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge: three configurations, a scoreboard of
// expected round results, and cycle-exact latency checks.
`timescale 1ns/1ps
module tb_hit_judge;

    localparam int ND = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [ND-1:0] rst_n;
    logic [ND-1:0] shot_valid;
    logic [ND-1:0] restart;
    logic [ND-1:0] shot_ready;
    logic [ND-1:0] result_valid;
    logic [ND-1:0] result_hit;
    logic [ND-1:0] game_over;
    logic [4:0]    tx    [ND];
    logic [4:0]    ty    [ND];
    logic [4:0]    sx    [ND];
    logic [4:0]    sy    [ND];
    logic [7:0]    score [ND];
    logic [1:0]    lives [ND];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int d;
        int hit;
        int score;
        int lives;
    } exp_t;

    exp_t sb [$];
    int   mscore [ND];
    int   mlives [ND];

    hit_judge #(.TIMEOUT_CYCLES(200), .LIVES(3), .TOL(0)) u_d0 (
        .clk(clk), .reset(rst_n[0]), .target_x(tx[0]), .target_y(ty[0]),
        .shot_valid(shot_valid[0]), .shot_x(sx[0]), .shot_y(sy[0]),
        .shot_ready(shot_ready[0]), .restart(restart[0]),
        .result_valid(result_valid[0]), .result_hit(result_hit[0]),
        .score(score[0]), .lives(lives[0]), .game_over(game_over[0]));

    hit_judge #(.TIMEOUT_CYCLES(4), .LIVES(3), .TOL(2)) u_d1 (
        .clk(clk), .reset(rst_n[1]), .target_x(tx[1]), .target_y(ty[1]),
        .shot_valid(shot_valid[1]), .shot_x(sx[1]), .shot_y(sy[1]),
        .shot_ready(shot_ready[1]), .restart(restart[1]),
        .result_valid(result_valid[1]), .result_hit(result_hit[1]),
        .score(score[1]), .lives(lives[1]), .game_over(game_over[1]));

    hit_judge #(.TIMEOUT_CYCLES(200), .LIVES(1), .TOL(0)) u_d2 (
        .clk(clk), .reset(rst_n[2]), .target_x(tx[2]), .target_y(ty[2]),
        .shot_valid(shot_valid[2]), .shot_x(sx[2]), .shot_y(sy[2]),
        .shot_ready(shot_ready[2]), .restart(restart[2]),
        .result_valid(result_valid[2]), .result_hit(result_hit[2]),
        .score(score[2]), .lives(lives[2]), .game_over(game_over[2]));

    function automatic int tol_of(input int d);
        return (d == 1) ? 2 : 0;
    endfunction

    function automatic int lives_of(input int d);
        return (d == 2) ? 1 : 3;
    endfunction

    function automatic int absd(input logic [4:0] a, input logic [4:0] b);
        int v;
        v = int'(a) - int'(b);
        return (v < 0) ? -v : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int d);
        mscore[d] = 0;
        mlives[d] = lives_of(d);
    endtask

    task automatic push_round(input int d, input int h);
        if (h != 0) begin
            if (mscore[d] < 255) mscore[d]++;
        end else if (mlives[d] > 0) begin
            mlives[d]--;
        end
        sb.push_back('{d, h, mscore[d], mlives[d]});
    endtask

    // Scoreboard: every result_valid pulse must match the oldest expected round.
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (result_valid[d] === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_result_valid", 32'(result_valid[d]), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result_instance", 32'(d), 32'(e.d));
                    check("result_hit", 32'(result_hit[d]), 32'(e.hit));
                    check("result_score", 32'(score[d]), 32'(e.score));
                    check("result_lives", 32'(lives[d]), 32'(e.lives));
                end
            end
        end
    end

    // Entered and left on a falling edge; shot accepted on the next rising edge.
    task automatic shoot(input int d, input logic [4:0] x, input logic [4:0] y,
                         input logic [4:0] tgx, input logic [4:0] tgy);
        int n;
        int h;
        n = 0;
        while (shot_ready[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_shot", 32'(shot_ready[d]), 32'd1);
        tx[d] = tgx;
        ty[d] = tgy;
        sx[d] = x;
        sy[d] = y;
        shot_valid[d] = 1'b1;
        h = ((absd(x, tgx) <= tol_of(d)) && (y == tgy)) ? 1 : 0;
        push_round(d, h);
        @(negedge clk);
        shot_valid[d] = 1'b0;
        check("judge_ready_low", 32'(shot_ready[d]), 32'd0);
        check("judge_no_valid", 32'(result_valid[d]), 32'd0);
        @(negedge clk);
        check("report_valid", 32'(result_valid[d]), 32'd1);
        @(negedge clk);
        check("post_report_valid_low", 32'(result_valid[d]), 32'd0);
        if (mlives[d] > 0) begin
            check("hold_ready_low", 32'(shot_ready[d]), 32'd0);
            @(negedge clk);
            check("rearm_ready", 32'(shot_ready[d]), 32'd1);
        end else begin
            check("over_flag", 32'(game_over[d]), 32'd1);
            check("over_ready_low", 32'(shot_ready[d]), 32'd0);
        end
    endtask

    task automatic release_reset(input int d);
        rst_n[d] = 1'b1;
        model_reset(d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] rx;
        logic [4:0] ry;
        rst_n      = '0;
        shot_valid = '0;
        restart    = '0;
        for (int d = 0; d < ND; d++) begin
            tx[d] = '0; ty[d] = '0; sx[d] = '0; sy[d] = '0;
            model_reset(d);
        end
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check("reset_ready", 32'(shot_ready[d]), 32'd1);
            check("reset_valid", 32'(result_valid[d]), 32'd0);
            check("reset_hit", 32'(result_hit[d]), 32'd0);
            check("reset_score", 32'(score[d]), 32'd0);
            check("reset_lives", 32'(lives[d]), 32'(lives_of(d)));
            check("reset_over", 32'(game_over[d]), 32'd0);
        end

        // Instance 0: basic hit, ignored restart, misses, saturation, mid-round reset.
        release_reset(0);
        shoot(0, 5'd12, 5'd1, 5'd12, 5'd1);
        check("first_hit_score", 32'(score[0]), 32'd1);
        restart[0] = 1'b1;
        @(negedge clk);
        restart[0] = 1'b0;
        @(negedge clk);
        check("restart_ignored_score", 32'(score[0]), 32'd1);
        check("restart_ignored_ready", 32'(shot_ready[0]), 32'd1);
        shoot(0, 5'd13, 5'd1, 5'd12, 5'd1);
        shoot(0, 5'd12, 5'd2, 5'd12, 5'd1);
        check("two_misses_lives", 32'(lives[0]), 32'd1);
        for (int i = 0; i < 253; i++) begin
            rx = 5'($urandom_range(0, 31));
            ry = 5'($urandom_range(0, 31));
            shoot(0, rx, ry, rx, ry);
        end
        check("preload_score", 32'(score[0]), 32'd254);
        for (int i = 0; i < 3; i++) begin
            shoot(0, 5'd31, 5'd0, 5'd31, 5'd0);
            check("saturated_score", 32'(score[0]), 32'd255);
        end
        tx[0] = 5'd4; ty[0] = 5'd4; sx[0] = 5'd4; sy[0] = 5'd4;
        shot_valid[0] = 1'b1;
        @(negedge clk);
        shot_valid[0] = 1'b0;
        rst_n[0] = 1'b0;
        @(negedge clk);
        release_reset(0);
        check("midreset_score", 32'(score[0]), 32'd0);
        check("midreset_lives", 32'(lives[0]), 32'd3);
        check("midreset_valid", 32'(result_valid[0]), 32'd0);
        @(negedge clk);
        check("midreset_ready_after_release", 32'(shot_ready[0]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midreset_no_result", 32'(result_valid[0]), 32'd0);
        end
        rst_n[0] = 1'b0;

        // Instance 1: tolerance, timeout to game over, restart, shot in expiry cycle.
        release_reset(1);
        shoot(1, 5'd7, 5'd0, 5'd5, 5'd0);
        shoot(1, 5'd8, 5'd0, 5'd5, 5'd0);
        check("tol_miss_lives", 32'(lives[1]), 32'd2);
        shoot(1, 5'd3, 5'd0, 5'd5, 5'd0);
        shoot(1, 5'd7, 5'd1, 5'd5, 5'd0);
        check("tol_score", 32'(score[1]), 32'd2);
        push_round(1, 0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("timeout_wait_no_valid", 32'(result_valid[1]), 32'd0);
            check("timeout_wait_ready", 32'(shot_ready[1]), 32'd1);
        end
        @(negedge clk);
        check("timeout_report_valid", 32'(result_valid[1]), 32'd1);
        @(negedge clk);
        check("timeout_game_over", 32'(game_over[1]), 32'd1);
        restart[1] = 1'b1;
        @(negedge clk);
        restart[1] = 1'b0;
        model_reset(1);
        check("restart_ready", 32'(shot_ready[1]), 32'd1);
        check("restart_lives", 32'(lives[1]), 32'd3);
        check("restart_score", 32'(score[1]), 32'd0);
        check("restart_hit", 32'(result_hit[1]), 32'd0);
        for (int k = 1; k <= 3; k++) @(negedge clk);
        shoot(1, 5'd6, 5'd0, 5'd5, 5'd0);
        check("expiry_shot_score", 32'(score[1]), 32'd1);
        check("expiry_shot_lives", 32'(lives[1]), 32'd3);
        rst_n[1] = 1'b0;

        // Instance 2: single life, game over holds under shots, restart.
        release_reset(2);
        shoot(2, 5'd9, 5'd9, 5'd9, 5'd9);
        shoot(2, 5'd4, 5'd3, 5'd3, 5'd3);
        shot_valid[2] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("over_ready_low_hold", 32'(shot_ready[2]), 32'd0);
            check("over_flag_hold", 32'(game_over[2]), 32'd1);
            check("over_score_hold", 32'(score[2]), 32'd1);
            check("over_lives_hold", 32'(lives[2]), 32'd0);
        end
        shot_valid[2] = 1'b0;
        restart[2] = 1'b1;
        @(negedge clk);
        restart[2] = 1'b0;
        model_reset(2);
        check("over_restart_ready", 32'(shot_ready[2]), 32'd1);
        check("over_restart_flag", 32'(game_over[2]), 32'd0);
        check("over_restart_score", 32'(score[2]), 32'd0);
        check("over_restart_lives", 32'(lives[2]), 32'd1);
        rst_n[2] = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hit_judge.md
HIT_JUDGE -- requirements
Module: hit_judge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 200, WAIT cycles without a shot before an automatic miss; legal range 2..1023.
REQ-002 Parameter LIVES, default 3, lives loaded at reset or restart; legal range 1..3.
REQ-003 Parameter TOL, default 0, allowed absolute X distance for a hit; legal range 0..31.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 target_x  in  5  current target X, from the target generator.
REQ-007 target_y  in  5  current target Y, from the target generator.
REQ-008 shot_valid  in  1  player shot request.
REQ-009 shot_x, shot_y  in  5 each  shot coordinates, sampled on acceptance.
REQ-010 shot_ready  out  1  high only in WAIT.
REQ-011 restart  in  1  new-game request, honoured only in OVER.
REQ-012 result_valid  out  1  one-cycle pulse per judged round; drives the target generator's enable.
REQ-013 result_hit  out  1  outcome of the last round; stable until the next result_valid.
REQ-014 score  out  8  hit count, saturating.
REQ-015 lives  out  2  remaining lives.
REQ-016 game_over  out  1  high in OVER.

Function
REQ-017 The FSM SHALL use states WAIT, JUDGE, REPORT, HOLD and OVER.
REQ-018 A shot is accepted on shot_valid & shot_ready; shot_x and shot_y are registered on that edge, and the FSM moves WAIT->JUDGE.
REQ-019 JUDGE computes a hit when |shot_x - target_x| <= TOL (6-bit signed difference, then absolute value) and shot_y == target_y (all 5 bits); JUDGE->REPORT.
REQ-020 In REPORT, result_valid=1 for exactly one cycle and result_hit is updated on entry; latency is shot accept at edge N, result_valid high during cycle N+2.
REQ-021 On a hit, score increments and holds at 255 (no wrap).
REQ-022 On a miss, lives decrements by 1 and never goes below 0.
REQ-023 REPORT->HOLD when lives > 0 after the update; otherwise REPORT->OVER.
REQ-024 HOLD lasts one cycle so the new target settles; HOLD->WAIT, and shot_ready is high again at cycle N+4.
REQ-025 The round timer clears on entry to WAIT and increments each WAIT cycle.
REQ-026 When the timer reaches TIMEOUT_CYCLES-1 with no shot accepted, WAIT->REPORT is taken as a miss, skipping JUDGE.
REQ-027 If shot_valid and timer expiry occur in the same cycle, the shot wins and the timeout is discarded.
REQ-028 In OVER: shot_ready=0, game_over=1, shot_valid ignored, and score and lives hold.
REQ-029 restart in OVER reloads lives=LIVES, clears score and result_hit, and goes to WAIT; restart in any other state is ignored.
REQ-030 Outputs are never X after the first reset edge.

Reset
REQ-031 On any clk edge with reset=0, from any state: state=WAIT, timer=0, score=0, lives=LIVES, result_valid=0, result_hit=0, game_over=0.
REQ-032 Reset in JUDGE or REPORT discards the pending round: no result_valid is produced and score and lives are unchanged from their reset values.
REQ-033 shot_ready is 1 in the first cycle after reset deasserts.

Structure
REQ-034 Package hit_judge_pkg holds the state enum, COORD_W=5, SCORE_W=8, LIVES_W=2 and TIMER_W=10.
REQ-035 One sub-module, round_timer, provides a counter with clear and enable and an expiry flag compared against TIMEOUT_CYCLES-1.
REQ-036 The FSM, hit compare, score and lives logic live in hit_judge.

Verification
REQ-037 Hit: target (12,1), TOL=0, shot (12,1) -> result_valid at N+2, result_hit=1, score 0->1, shot_ready high at N+4.
REQ-038 Tolerance: TOL=2, target (5,0); shot (7,0) -> hit; shot (8,0) -> miss, lives 3->2; shot (3,0) -> hit; shot (7,1) -> miss.
REQ-039 Timeout: TIMEOUT_CYCLES=4, no shot -> result_valid with result_hit=0 exactly 4 cycles after entering WAIT, lives decremented; a shot in the expiry cycle -> judged normally.
REQ-040 Game over: LIVES=1, one miss -> game_over=1, shot_ready=0, shots ignored for 20 cycles; restart pulse -> WAIT with score=0 and lives=1.
REQ-041 Saturation: score preloaded to 254 via hits, 3 more hits -> score=255 and stays 255.
REQ-042 Reset mid-round: reset=0 in the JUDGE cycle -> no result_valid, score=0, lives=LIVES, shot_ready=1 the cycle after release.
